pulse_schedule_ctrl: RTL and testbench
======================================

# pulse_schedule_ctrl

Sequencer that owns one pulse generator channel and runs a host-loaded queue of timed pulse trains on it. Each queue entry holds a start time of day, high width, period and duration in seconds. The controller drives the generator's enable, date/time and width/period inputs. It arms the generator for the head entry, keeps the train running for exactly the programmed number of PPS seconds, then deasserts enable and advances to the next entry. It sits between the host register bank and `pulse_generator`.

## Interface
- `DEPTH`, 4: queue entries; must be a power of two, ≥2.
- `DUR_W`, 16: width of the duration field (seconds).
- `i_clk` in 1: system clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_pps_raw` in 1: raw PPS; rising edge detected through a 2-flop shift register (`2'b01`).
- `i_push` in 1: write the entry fields into the queue tail.
- `i_start_hour` / `i_start_minutes` / `i_start_seconds` in 8/8/8: entry start time.
- `i_width_high` in 24: entry high width (µs).
- `i_width_period` in 24: entry period (µs).
- `i_duration` in DUR_W: entry run length in PPS seconds.
- `i_abort` in 1: terminate the active entry.
- `i_thunder_packet_dv` in 1: Thunderbolt time valid strobe.
- `i_thunder_year` in 16: Thunderbolt year.
- `i_thunder_month` / `i_thunder_day` / `i_thunder_hour` / `i_thunder_minutes` / `i_thunder_seconds` in 8 each: Thunderbolt date and time.
- `o_pulse_enable` out 8: to generator; bit0 = run, bits[7:1] = 0.
- `o_usr_year` out 16, `o_usr_month` / `o_usr_day` / `o_usr_hour` / `o_usr_minutes` / `o_usr_seconds` out 8 each: to generator.
- `o_width_high` / `o_width_period` out 24 each: to generator.
- `o_full` out 1, `o_empty` out 1, `o_count` out log2(DEPTH)+1: queue status.
- `o_busy` out 1: high in any state except IDLE.
- `o_done` out 1: one-cycle strobe when an entry retires.

## Operation
- Queue: circular buffer with read/write pointers and an occupancy count.
  - A push is accepted only if `o_full` was low in the same cycle. A push while full is dropped; there is no bypass.
  - Pop happens only in GAP.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Time-of-day latch: on `i_thunder_packet_dv` the thunder fields are registered into `r_tod`.
  - `match` = `r_tod` hour, minutes and seconds equal the head entry start.
- FSM states:
  - **IDLE**: enable low. If not empty, go to LOAD.
  - **LOAD** (1 cycle): copy the head entry into the output registers.
    - `o_usr_year/month/day` take the `r_tod` date; `o_usr_hour/min/sec` take the entry start.
    - Clear the second counter.
    - If `i_duration`==0 or `i_width_period`==0, go to GAP (skip, never enabled); else go to ARM.
  - **ARM**: `o_pulse_enable[0]`=1. On a PPS rising edge with `match`, go to RUN.
  - **RUN**: enable high.
    - Each later PPS rising edge increments the second counter; the edge that entered RUN is not counted.
    - When the counter reaches `duration`, go to GAP. The train therefore lasts exactly `duration` seconds.
  - **GAP** (2 cycles): enable low, which guarantees the generator resets.
    - On the first cycle: pop the head and pulse `o_done`.
    - Then go to IDLE.
- `i_abort` in ARM or RUN forces GAP next cycle (the entry is popped). `i_abort` in other states is ignored.
- Reset mid-operation: the next edge clears the queue, pointers, FSM and outputs. Enable drops the cycle after `i_rst` is sampled.

## Timing
- Reset values:
  - `o_pulse_enable`=0, all `o_usr_*`=0, `o_width_*`=0.
  - `o_full`=0, `o_empty`=1, `o_count`=0.
  - `o_busy`=0, `o_done`=0.
- Push at edge N: `o_count` and `o_empty` update at N+1. From IDLE, LOAD occurs at N+1 and enable rises at N+2.
- PPS edge detect adds 2 cycles of latency from `i_pps_raw`. The RUN→GAP transition is registered the cycle the edge is detected, and enable falls 1 cycle later.
- Minimum enable-low gap between consecutive entries: 3 cycles (GAP ×2 + LOAD).
- All outputs are registered; config outputs stay stable for the whole time enable is high.
- Counter wraps are impossible: the counter compares with `==` against a non-zero duration.

## Configuration
- `PULSE_SCHED_LOOP_EN`:
  - When defined, a retired entry that was not aborted and not skipped is re-written to the queue tail in the same cycle as its pop. The count stays unchanged, so the schedule repeats forever until an abort or reset.
  - When undefined, retired entries are discarded.

## Test plan
- Push one entry {12:00:05, high=10, period=100, dur=3}; drive tod 12:00:05 then PPS → enable rises 2 cycles after the push. Enable stays high across exactly 3 later PPS edges, then falls; `o_done` pulses once; `o_empty`=1.
- Push 5 entries with DEPTH=4 → the 5th is dropped; `o_full`=1; `o_count`=4; after one retire, `o_count`=3.
- Entry with dur=0 → enable never rises; `o_done` pulses; the next entry loads.
- `i_abort` in RUN after 1 of 5 seconds → enable low the next cycle; entry popped; `o_done`=1.
- `i_rst` asserted in RUN with 3 entries queued → next cycle: all outputs at reset values, `o_count`=0.
- With `PULSE_SCHED_LOOP_EN`, 2 entries of dur=1 → they alternate indefinitely; `o_count` stays 2.

Source files
------------

// File: rtl/pulse_schedule_ctrl_if.sv
// -----------------------------------------------------------------------------
// pulse_schedule_ctrl_if
//
// Host-side bus of pulse_schedule_ctrl: queue write port, abort request and
// queue/sequencer status.
//
// Handshake: an entry is transferred on a rising clock edge where i_push is
// high and o_full is low. o_full is registered, so the host can decide whether
// to push from the value it sees in the same cycle. A push while o_full is
// high is dropped. i_abort is a single-cycle request with no acknowledge; its
// effect is visible through o_done and o_busy.
//
// Signals (direction as seen by the controller / slave modport):
//   i_push                  in   write entry fields into the queue tail
//   i_start_hour/minutes/seconds in 8 each, entry start time of day
//   i_width_high            in   24, high width (us)
//   i_width_period          in   24, period (us)
//   i_duration              in   DUR_W, run length in PPS seconds
//   i_abort                 in   terminate the active entry
//   o_full / o_empty        out  queue status
//   o_count                 out  log2(DEPTH)+1, queue occupancy
//   o_busy                  out  sequencer not idle
//   o_done                  out  one-cycle strobe when an entry retires
// -----------------------------------------------------------------------------
interface pulse_schedule_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int DUR_W = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             i_push;
  logic [7:0]       i_start_hour;
  logic [7:0]       i_start_minutes;
  logic [7:0]       i_start_seconds;
  logic [23:0]      i_width_high;
  logic [23:0]      i_width_period;
  logic [DUR_W-1:0] i_duration;
  logic             i_abort;
  logic             o_full;
  logic             o_empty;
  logic [CNT_W-1:0] o_count;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_push, i_start_hour, i_start_minutes, i_start_seconds,
           i_width_high, i_width_period, i_duration, i_abort,
    input  o_full, o_empty, o_count, o_busy, o_done
  );

  modport slave (
    input  i_push, i_start_hour, i_start_minutes, i_start_seconds,
           i_width_high, i_width_period, i_duration, i_abort,
    output o_full, o_empty, o_count, o_busy, o_done
  );
endinterface

// File: rtl/pulse_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_schedule_ctrl
//
// Owns one pulse_generator channel and plays a host-loaded queue of timed
// pulse trains on it. For the head entry it loads the generator config, arms
// the generator, waits for a PPS edge at the entry's start time of day, keeps
// the train running for exactly `duration` further PPS seconds, then drops
// enable for two cycles (so the generator resets) and retires the entry.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_pps_raw           raw PPS, rising edge detected after a 2-flop shifter
//   host                pulse_schedule_ctrl_if.slave: queue write, abort, status
//   i_thunder_*         Thunderbolt date/time, latched on i_thunder_packet_dv
//   o_pulse_enable      bit0 = generator run, bits[7:1] = 0
//   o_usr_*             date/time handed to the generator
//   o_width_high/period generator width/period (us)
//   o_fsm_state         current sequencer state (debug)
//
// Build option: define PULSE_SCHED_LOOP_EN to re-queue every entry that
// retires normally (not aborted, not skipped), so the schedule repeats.
// -----------------------------------------------------------------------------
module pulse_schedule_ctrl #(
  parameter int DEPTH = 4,
  parameter int DUR_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pps_raw,
  pulse_schedule_ctrl_if.slave host,
  input  logic        i_thunder_packet_dv,
  input  logic [15:0] i_thunder_year,
  input  logic [7:0]  i_thunder_month,
  input  logic [7:0]  i_thunder_day,
  input  logic [7:0]  i_thunder_hour,
  input  logic [7:0]  i_thunder_minutes,
  input  logic [7:0]  i_thunder_seconds,
  output logic [7:0]  o_pulse_enable,
  output logic [15:0] o_usr_year,
  output logic [7:0]  o_usr_month,
  output logic [7:0]  o_usr_day,
  output logic [7:0]  o_usr_hour,
  output logic [7:0]  o_usr_minutes,
  output logic [7:0]  o_usr_seconds,
  output logic [23:0] o_width_high,
  output logic [23:0] o_width_period,
  output logic [2:0]  o_fsm_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DUR_W + 72;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_GAP1 = 3'd4;
  localparam logic [2:0] S_GAP2 = 3'd5;

  // Queue storage; entry layout {hour, min, sec, high, period, duration}
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full, r_empty;

  logic [2:0]       r_state;
  logic [1:0]       r_pps_sr;
  logic [DUR_W-1:0] r_sec;

  logic [15:0]      r_tod_year;
  logic [7:0]       r_tod_month, r_tod_day, r_tod_hour, r_tod_minutes, r_tod_seconds;

  logic             r_enable, r_busy, r_done;
  logic [15:0]      r_usr_year;
  logic [7:0]       r_usr_month, r_usr_day, r_usr_hour, r_usr_minutes, r_usr_seconds;
  logic [23:0]      r_width_high, r_width_period;

  logic [ENT_W-1:0] w_head, w_host_data, w_wr_data;
  logic [7:0]       w_head_hour, w_head_minutes, w_head_seconds;
  logic [23:0]      w_head_high, w_head_period;
  logic [DUR_W-1:0] w_head_dur, w_sec_inc;
  logic             w_pps_rise, w_match, w_skip;
  logic             w_push_acc, w_pop, w_loop_wr, w_wr_en, w_have_entry;
  logic [CNT_W-1:0] w_count_nxt;
  logic [2:0]       w_next;

  assign w_head         = r_mem[r_rd_ptr];
  assign w_head_hour    = w_head[DUR_W+64 +: 8];
  assign w_head_minutes = w_head[DUR_W+56 +: 8];
  assign w_head_seconds = w_head[DUR_W+48 +: 8];
  assign w_head_high    = w_head[DUR_W+24 +: 24];
  assign w_head_period  = w_head[DUR_W    +: 24];
  assign w_head_dur     = w_head[0 +: DUR_W];

  assign w_host_data = {host.i_start_hour, host.i_start_minutes, host.i_start_seconds,
                        host.i_width_high, host.i_width_period, host.i_duration};

  assign w_pps_rise = (r_pps_sr == 2'b01);
  assign w_match    = (r_tod_hour == w_head_hour) && (r_tod_minutes == w_head_minutes) &&
                      (r_tod_seconds == w_head_seconds);
  assign w_skip     = (w_head_dur == '0) || (w_head_period == '0);
  assign w_sec_inc  = r_sec + 1'b1;

  // Pop happens only in the first gap cycle; the head is valid until then.
  assign w_pop = (r_state == S_GAP1);

`ifdef PULSE_SCHED_LOOP_EN
  // Remembers whether the loaded entry must not be re-queued (skip or abort).
  logic r_no_loop;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_no_loop <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_no_loop <= w_skip;
    end else if ((r_state == S_ARM || r_state == S_RUN) && host.i_abort) begin
      r_no_loop <= 1'b1;
    end
  end
  assign w_loop_wr = w_pop && !r_no_loop;
`else
  assign w_loop_wr = 1'b0;
`endif

  // The recycle write owns the tail port in its cycle; a host push there is dropped.
  assign w_push_acc   = host.i_push && !r_full && !w_loop_wr;
  assign w_wr_en      = w_push_acc || w_loop_wr;
  assign w_wr_data    = w_loop_wr ? w_head : w_host_data;
  assign w_have_entry = !r_empty || w_push_acc;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_en && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr_en && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_have_entry) w_next = S_LOAD;
      S_LOAD: w_next = w_skip ? S_GAP1 : S_ARM;
      S_ARM: begin
        if (host.i_abort)               w_next = S_GAP1;
        else if (w_pps_rise && w_match) w_next = S_RUN;
      end
      S_RUN: begin
        if (host.i_abort)                             w_next = S_GAP1;
        else if (w_pps_rise && w_sec_inc == w_head_dur) w_next = S_GAP1;
      end
      S_GAP1: w_next = S_GAP2;
      // Going straight to LOAD keeps the enable-low gap at three cycles.
      S_GAP2: w_next = w_have_entry ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_pps_sr       <= 2'b00;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_sec          <= '0;
      r_tod_year     <= '0;
      r_tod_month    <= '0;
      r_tod_day      <= '0;
      r_tod_hour     <= '0;
      r_tod_minutes  <= '0;
      r_tod_seconds  <= '0;
      r_enable       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_usr_year     <= '0;
      r_usr_month    <= '0;
      r_usr_day      <= '0;
      r_usr_hour     <= '0;
      r_usr_minutes  <= '0;
      r_usr_seconds  <= '0;
      r_width_high   <= '0;
      r_width_period <= '0;
    end else begin
      r_state  <= w_next;
      r_pps_sr <= {r_pps_sr[0], i_pps_raw};

      if (i_thunder_packet_dv) begin
        r_tod_year    <= i_thunder_year;
        r_tod_month   <= i_thunder_month;
        r_tod_day     <= i_thunder_day;
        r_tod_hour    <= i_thunder_hour;
        r_tod_minutes <= i_thunder_minutes;
        r_tod_seconds <= i_thunder_seconds;
      end

      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);

      if (r_state == S_LOAD) begin
        r_usr_year     <= r_tod_year;
        r_usr_month    <= r_tod_month;
        r_usr_day      <= r_tod_day;
        r_usr_hour     <= w_head_hour;
        r_usr_minutes  <= w_head_minutes;
        r_usr_seconds  <= w_head_seconds;
        r_width_high   <= w_head_high;
        r_width_period <= w_head_period;
        r_sec          <= '0;
      end else if (r_state == S_RUN && w_pps_rise) begin
        // The edge that entered RUN was seen in ARM, so only later edges land here.
        r_sec <= w_sec_inc;
      end

      // Outputs follow the next state so they are registered yet cycle-aligned.
      r_enable <= (w_next == S_ARM) || (w_next == S_RUN);
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_GAP1);
    end
  end

  assign o_pulse_enable = {7'b0, r_enable};
  assign o_usr_year     = r_usr_year;
  assign o_usr_month    = r_usr_month;
  assign o_usr_day      = r_usr_day;
  assign o_usr_hour     = r_usr_hour;
  assign o_usr_minutes  = r_usr_minutes;
  assign o_usr_seconds  = r_usr_seconds;
  assign o_width_high   = r_width_high;
  assign o_width_period = r_width_period;
  assign o_fsm_state    = r_state;

  assign host.o_full  = r_full;
  assign host.o_empty = r_empty;
  assign host.o_count = r_count;
  assign host.o_busy  = r_busy;
  assign host.o_done  = r_done;

endmodule

// File: tb/tb_pulse_schedule_ctrl.sv
`timescale 1ns/1ps
module tb_pulse_schedule_ctrl;

  localparam int DEPTH = 4;
  localparam int DUR_W = 16;
  localparam int ENT_W = DUR_W + 72;
`ifdef PULSE_SCHED_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]       h;
    logic [7:0]       m;
    logic [7:0]       s;
    logic [23:0]      hi;
    logic [23:0]      per;
    logic [DUR_W-1:0] dur;
  } ent_t;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pps_raw = 1'b0;
  logic        dv = 1'b0;
  logic [15:0] th_year = '0;
  logic [7:0]  th_month = '0, th_day = '0, th_hour = '0, th_min = '0, th_sec = '0;

  logic [7:0]  o_pulse_enable;
  logic [15:0] o_usr_year;
  logic [7:0]  o_usr_month, o_usr_day, o_usr_hour, o_usr_minutes, o_usr_seconds;
  logic [23:0] o_width_high, o_width_period;
  logic [2:0]  o_fsm_state;

  always #5 clk = ~clk;

  pulse_schedule_ctrl_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

  pulse_schedule_ctrl #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_pps_raw           (pps_raw),
    .host                (bus),
    .i_thunder_packet_dv (dv),
    .i_thunder_year      (th_year),
    .i_thunder_month     (th_month),
    .i_thunder_day       (th_day),
    .i_thunder_hour      (th_hour),
    .i_thunder_minutes   (th_min),
    .i_thunder_seconds   (th_sec),
    .o_pulse_enable      (o_pulse_enable),
    .o_usr_year          (o_usr_year),
    .o_usr_month         (o_usr_month),
    .o_usr_day           (o_usr_day),
    .o_usr_hour          (o_usr_hour),
    .o_usr_minutes       (o_usr_minutes),
    .o_usr_seconds       (o_usr_seconds),
    .o_width_high        (o_width_high),
    .o_width_period      (o_width_period),
    .o_fsm_state         (o_fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [ENT_W-1:0] exp_q[$];
  logic [15:0] cur_year;
  logic [7:0]  cur_month, cur_day;

  always @(negedge clk) if (bus.o_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t rand_ent(input int dmin, input int dmax);
    ent_t e;
    e.h   = 8'($urandom_range(0, 23));
    e.m   = 8'($urandom_range(0, 59));
    e.s   = 8'($urandom_range(0, 59));
    e.hi  = 24'($urandom_range(1, 1000));
    e.per = e.hi + 24'($urandom_range(1, 1000));
    e.dur = DUR_W'($urandom_range(dmin, dmax));
    return e;
  endfunction

  // Head leaves the queue; a normal retirement goes back to the tail when looping.
  task automatic retire_model(input bit natural);
    logic [ENT_W-1:0] v;
    v = exp_q.pop_front();
    if (natural && LOOP_EN) exp_q.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.i_push = 1'b0; bus.i_abort = 1'b0; pps_raw = 1'b0; dv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cur_year  = 16'($urandom_range(2000, 2099));
    cur_month = 8'($urandom_range(1, 12));
    cur_day   = 8'($urandom_range(1, 28));
  endtask

  task automatic set_tod(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge clk);
    th_year = cur_year; th_month = cur_month; th_day = cur_day;
    th_hour = h; th_min = m; th_sec = s; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic push_ent(input ent_t e);
    @(negedge clk);
    bus.i_start_hour = e.h; bus.i_start_minutes = e.m; bus.i_start_seconds = e.s;
    bus.i_width_high = e.hi; bus.i_width_period = e.per; bus.i_duration = e.dur;
    bus.i_push = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    @(negedge clk);
    bus.i_push = 1'b0;
  endtask

  task automatic abort_pulse();
    @(negedge clk) bus.i_abort = 1'b1;
    @(negedge clk) bus.i_abort = 1'b0;
  endtask

  // Low for two samples, then high; returns once the FSM has reacted.
  task automatic pps_rise();
    @(negedge clk) pps_raw = 1'b0;
    @(negedge clk);
    @(negedge clk) pps_raw = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_en(input logic val, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_pulse_enable[0] === val) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic chk_cfg(input string tag);
    ent_t e;
    e = exp_q[0];
    chk({tag, "_hour"},   o_usr_hour,     e.h);
    chk({tag, "_min"},    o_usr_minutes,  e.m);
    chk({tag, "_sec"},    o_usr_seconds,  e.s);
    chk({tag, "_high"},   o_width_high,   e.hi);
    chk({tag, "_period"}, o_width_period, e.per);
    chk({tag, "_year"},   o_usr_year,     cur_year);
    chk({tag, "_month"},  o_usr_month,    cur_month);
    chk({tag, "_day"},    o_usr_day,      cur_day);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_enable"}, o_pulse_enable, 8'h00);
    chk({tag, "_usr"}, {o_usr_year, o_usr_month, o_usr_day, o_usr_hour, o_usr_minutes, o_usr_seconds}, '0);
    chk({tag, "_width"}, {o_width_high, o_width_period}, '0);
    chk({tag, "_full"},  bus.o_full,  1'b0);
    chk({tag, "_empty"}, bus.o_empty, 1'b1);
    chk({tag, "_count"}, bus.o_count, 0);
    chk({tag, "_busy"},  bus.o_busy,  1'b0);
    chk({tag, "_done"},  bus.o_done,  1'b0);
  endtask

  // Plays the head entry to its natural end; returns in the second gap cycle.
  task automatic run_head(input bit probe);
    ent_t e;
    int d0;
    e = exp_q[0];
    wait_en(1'b1, 10, "arm_timeout");
    chk_cfg("cfg");
    if (probe) begin
      set_tod(e.h + 8'd1, e.m, e.s);
      pps_rise();
      chk("nomatch_en", o_pulse_enable, 8'h01);
    end
    set_tod(e.h, e.m, e.s);
    pps_rise();
    chk("run_en", o_pulse_enable, 8'h01);
    for (int i = 1; i < int'(e.dur); i++) begin
      pps_rise();
      chk("run_hold_en", o_pulse_enable, 8'h01);
    end
    d0 = done_cnt;
    @(negedge clk) pps_raw = 1'b0;
    @(negedge clk);
    @(negedge clk) pps_raw = 1'b1;
    @(negedge clk);
    chk("last_edge_en", o_pulse_enable[0], 1'b1);
    @(negedge clk);
    chk("en_fall", o_pulse_enable[0], 1'b0);
    chk("done_pulse", bus.o_done, 1'b1);
    retire_model(1'b1);
    @(negedge clk);
    chk("retire_count", bus.o_count, exp_q.size());
    chk("retire_empty", bus.o_empty, exp_q.size() == 0);
    chk("done_low", bus.o_done, 1'b0);
    #1;
    chk("done_once", done_cnt - d0, 1);
    pps_raw = 1'b0;
  endtask

  // ---------------- tests ----------------
  initial begin
    ent_t e, a, b;
    int d0, seen;
    bus.i_push = 1'b0; bus.i_abort = 1'b0;
    bus.i_start_hour = '0; bus.i_start_minutes = '0; bus.i_start_seconds = '0;
    bus.i_width_high = '0; bus.i_width_period = '0; bus.i_duration = '0;

    do_reset();
    chk_reset_outputs("por");

    // abort while idle is ignored
    d0 = done_cnt;
    abort_pulse();
    @(negedge clk);
    #1;
    chk("idle_abort_busy", bus.o_busy, 1'b0);
    chk("idle_abort_done", done_cnt - d0, 0);

    // single random entries: timing from push, exact PPS run length
    repeat (5) begin
      do_reset();
      e = rand_ent(1, 3);
      set_tod(e.h, e.m, e.s);
      push_ent(e);
      chk("push_count", bus.o_count, 1);
      chk("push_empty", bus.o_empty, 1'b0);
      chk("load_en_low", o_pulse_enable[0], 1'b0);
      chk("load_busy", bus.o_busy, 1'b1);
      @(negedge clk);
      chk("en_two_after_push", o_pulse_enable[0], 1'b1);
      run_head(1'b1);
    end

    // queue full: fifth push dropped, entries retire in order by abort
    do_reset();
    set_tod(8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      e = rand_ent(1, 3);
      e.h = 8'($urandom_range(1, 23));
      push_ent(e);
    end
    chk("full_count", bus.o_count, 4);
    chk("full_flag", bus.o_full, 1'b1);
    while (exp_q.size() > 0) begin
      wait_en(1'b1, 10, "full_arm_timeout");
      chk_cfg("full_cfg");
      abort_pulse();
      chk("arm_abort_en", o_pulse_enable[0], 1'b0);
      chk("arm_abort_done", bus.o_done, 1'b1);
      retire_model(1'b0);
      @(negedge clk);
      chk("arm_abort_count", bus.o_count, exp_q.size());
      chk("arm_abort_full", bus.o_full, 1'b0);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_pulse_enable[0]) seen++;
    end
    chk("dropped_never_runs", seen, 0);
    chk("drained_empty", bus.o_empty, 1'b1);

    // skipped entry (duration or period zero) followed by a normal one
    repeat (2) begin
      do_reset();
      a = rand_ent(1, 3);
      if ($urandom_range(0, 1) == 0) a.dur = '0;
      else a.per = '0;
      b = rand_ent(1, 2);
      set_tod(b.h, b.m, b.s);
      d0 = done_cnt;
      push_ent(a);
      chk("skip_en_low", o_pulse_enable[0], 1'b0);
      push_ent(b);
      retire_model(1'b0);
      chk("skip_en_never", o_pulse_enable[0], 1'b0);
      #1;
      chk("skip_done", done_cnt - d0, 1);
      run_head(1'b0);
    end

    // abort in RUN after 1 of 5 seconds
    do_reset();
    e = rand_ent(5, 5);
    set_tod(e.h, e.m, e.s);
    push_ent(e);
    wait_en(1'b1, 10, "abort_arm_timeout");
    pps_rise();
    pps_rise();
    chk("abort_pre_en", o_pulse_enable[0], 1'b1);
    d0 = done_cnt;
    abort_pulse();
    chk("run_abort_en", o_pulse_enable[0], 1'b0);
    chk("run_abort_done", bus.o_done, 1'b1);
    retire_model(1'b0);
    @(negedge clk);
    chk("run_abort_count", bus.o_count, 0);
    chk("run_abort_empty", bus.o_empty, 1'b1);
    #1;
    chk("run_abort_done_once", done_cnt - d0, 1);

    // reset in RUN with three entries queued
    do_reset();
    e = rand_ent(3, 3);
    set_tod(e.h, e.m, e.s);
    push_ent(e);
    push_ent(rand_ent(1, 3));
    push_ent(rand_ent(1, 3));
    chk("rst_pre_count", bus.o_count, 3);
    wait_en(1'b1, 10, "rst_arm_timeout");
    pps_rise();
    chk("rst_pre_en", o_pulse_enable[0], 1'b1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrun_rst");
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_pulse_enable[0]) seen++;
    end
    chk("post_rst_idle", seen, 0);

    // two back-to-back entries of one second: minimum gap, loop behaviour
    do_reset();
    a = rand_ent(1, 1);
    b = rand_ent(1, 1);
    b.h = a.h; b.m = a.m; b.s = a.s;
    set_tod(a.h, a.m, a.s);
    push_ent(a);
    push_ent(b);
    for (int k = 0; k < 4; k++) begin
      if (exp_q.size() == 0) break;
      run_head(1'b0);
      if (exp_q.size() > 0) begin
        @(negedge clk);
        chk("gap_load_en", o_pulse_enable[0], 1'b0);
        @(negedge clk);
        chk("gap_rearm_en", o_pulse_enable[0], 1'b1);
      end
    end
    chk("b2b_final_count", bus.o_count, exp_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
